alu_issue_stage: RTL
====================

# alu_issue_stage

Command front-end and result stage for the 32-bit unsigned ALU. Accepts ALU commands over a valid/ready handshake, buffers them in a small FIFO, presents the head command to the combinational ALU, and captures the ALU's result and carry into a registered valid/ready output. Also keeps a carry flag so consecutive ADDs can be chained into multi-word additions.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥ 2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  command present
- in_ready  out  1  stage can accept; = (count < DEPTH)
- in_opcode  in  3  ALU opcode: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 SHL, 5 SHR, 6 CUT, 7 ADD
- in_a  in  32  operand 1
- in_b  in  32  operand 2
- in_cin  in  1  explicit carry-in for ADD
- in_chain  in  1  ADD only: use carry_flag instead of in_cin
- carry_clr  in  1  synchronous clear of carry_flag
- alu_opcode  out  3  to ALU; head entry opcode, 0 when empty
- alu_a  out  32  to ALU; head in_a, 0 when empty
- alu_b  out  32  to ALU; head in_b, 0 when empty
- alu_cin  out  1  to ALU; head chain ? carry_flag : head cin; 0 when empty
- alu_result  in  32  from ALU
- alu_cout  in  1  from ALU (already gated to ADD)
- out_valid  out  1  result register holds data
- out_ready  in  1  consumer takes result
- out_result  out  32  registered result
- out_cout  out  1  registered carry-out
- out_opcode  out  3  opcode that produced out_result
- carry_flag  out  1  carry from last issued ADD
- count  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- Reset (async assert, sync-safe release): FIFO empty, rd/wr pointers 0, count 0, out_valid 0, out_result 0, out_cout 0, out_opcode 0, carry_flag 0. Reset mid-operation drops all queued and held commands.
- Push: in_valid && in_ready at edge stores {opcode, a, b, cin, chain} at wr_ptr; wr_ptr wraps modulo DEPTH. No bypass: in_ready low when full even if pop occurs same cycle.
- Issue condition: count ≠ 0 && (!out_valid || out_ready). At that edge: out_result ← alu_result, out_cout ← alu_cout, out_opcode ← head opcode, out_valid ← 1, pop head (rd_ptr wraps).
- Drain without issue: out_valid && out_ready && count == 0 → out_valid ← 0; data registers hold last value.
- Simultaneous push and pop: count unchanged; both pointers advance.
- carry_flag: on issue of ADD (opcode 7) ← alu_cout. Non-ADD issues leave it untouched. carry_clr clears it, except when an ADD issues the same cycle: issue wins.
- in_chain ignored for non-ADD opcodes; chained ADD sees carry_flag as of issue cycle, i.e. cout of the most recently issued ADD.
- ALU is purely combinational; alu_* outputs are combinational from FIFO head and carry_flag only (no path from in_* to alu_*).

## Timing
- Accept at edge k → earliest issue at edge k+1 → out_valid high after edge k+1 (one-cycle minimum latency, registered output).
- Throughput: one command per cycle with out_ready held high.
- out_valid/out_result stable while out_valid && !out_ready.
- Back-to-back chained ADDs issue on consecutive cycles; carry_flag updated at issue edge is visible to next head in the following cycle.
- Maximum in-flight: DEPTH in FIFO + 1 in output register.

## Test plan
- Single op: push XOR a=0xF0F0F0F0 b=0xFFFF0000, out_ready=1 → one cycle after accept out_valid=1, out_result=0x0F0FF0F0, out_cout=0, carry_flag unchanged.
- 64-bit add: ADD a=0xFFFFFFFF b=0x00000001 cin=0, then ADD chain=1 a=0 b=0 → results 0x00000000/cout 1, then 0x00000001/cout 0; carry_flag ends 0.
- Carry preserved across non-ADD: ADD 0x80000000+0x80000000 (cout 1), AND, then chained ADD 5+6 → 0x0000000C; carry_clr asserted alone before chained ADD instead → 0x0000000B.
- Backpressure, DEPTH=4, out_ready=0: stream 6 commands → exactly 5 accepted, in_ready low, count=4; release out_ready → results emerge in push order, one per cycle, no loss or duplication across pointer wrap.
- Simultaneous carry_clr with ADD issue producing cout 1 → carry_flag=1.
- Reset asserted asynchronously with 3 queued and out_valid=1 → immediately out_valid=0, count=0, in_ready=1, carry_flag=0; post-reset command processed normally.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ALU issue stage: buffers ALU commands in a small FIFO, presents the head
// command to an external combinational ALU and registers its result behind a
// valid/ready output. Tracks the carry of the last issued ADD so that chained
// ADDs can build multi-word sums.
module alu_issue_stage #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // Command input
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_opcode,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic                     in_cin,
  input  logic                     in_chain,
  input  logic                     carry_clr,
  // Combinational ALU interface
  output logic [2:0]               alu_opcode,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic                     alu_cin,
  input  logic [31:0]              alu_result,
  input  logic                     alu_cout,
  // Result output
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_cout,
  output logic [2:0]               out_opcode,
  output logic                     carry_flag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [2:0]  OpAdd = 3'd7;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        chain;
  } cmd_t;

  cmd_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic        out_cout_q, out_cout_d;
  logic [2:0]  out_opcode_q, out_opcode_d;
  logic        carry_q, carry_d;

  cmd_t head;
  cmd_t in_cmd;
  logic head_valid;
  logic push;
  logic issue;

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  // No bypass: a full FIFO refuses input even if the head leaves this cycle.
  assign in_ready   = (count_q < CntW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign issue      = head_valid && (!out_valid_q || out_ready);

  assign in_cmd = '{opcode: in_opcode, a: in_a, b: in_b, cin: in_cin, chain: in_chain};

  // Present the head command to the ALU; all zero when the FIFO is empty.
  always_comb begin
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_cin    = 1'b0;
    if (head_valid) begin
      alu_opcode = head.opcode;
      alu_a      = head.a;
      alu_b      = head.b;
      alu_cin    = head.chain ? carry_q : head.cin;
    end
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = push  ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = issue ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, issue})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Result register and carry flag next-state; an issuing ADD beats carry_clr.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_cout_d   = out_cout_q;
    out_opcode_d = out_opcode_q;
    carry_d      = carry_q;
    if (issue) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_cout_d   = alu_cout;
      out_opcode_d = head.opcode;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (issue && (head.opcode == OpAdd)) begin
      carry_d = alu_cout;
    end else if (carry_clr) begin
      carry_d = 1'b0;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_cmd;
    end
  end

  // Control and result state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_cout_q   <= 1'b0;
      out_opcode_q <= '0;
      carry_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_cout_q   <= out_cout_d;
      out_opcode_q <= out_opcode_d;
      carry_q      <= carry_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_cout   = out_cout_q;
  assign out_opcode = out_opcode_q;
  assign carry_flag = carry_q;
  assign count      = count_q;

endmodule
